// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: instruction class codes,
// MDU operation codes, default latencies and the class-to-operation decode.
package mdu_pkg;

    localparam logic [3:0] CLS_NONE  = 4'd0;
    localparam logic [3:0] CLS_MULT  = 4'd1;
    localparam logic [3:0] CLS_MULTU = 4'd2;
    localparam logic [3:0] CLS_DIV   = 4'd3;
    localparam logic [3:0] CLS_DIVU  = 4'd4;
    localparam logic [3:0] CLS_MTHI  = 4'd5;
    localparam logic [3:0] CLS_MTLO  = 4'd6;
    localparam logic [3:0] CLS_MFHI  = 4'd7;
    localparam logic [3:0] CLS_MFLO  = 4'd8;

    localparam logic [2:0] OP_MULU = 3'b000;
    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_DIVU = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_MR   = 3'b100;

    localparam int MUL_LAT_DEF  = 5;
    localparam int DIV_LAT_DEF  = 10;
    localparam int WD_SLACK_DEF = 2;

    // Non-start classes decode to the reserved code; callers only use the result on a start.
    function automatic logic [2:0] cls_to_op(input logic [3:0] cls);
        logic [2:0] op;
        case (cls)
            CLS_MULT:  op = OP_MUL;
            CLS_MULTU: op = OP_MULU;
            CLS_DIV:   op = OP_DIV;
            CLS_DIVU:  op = OP_DIVU;
            default:   op = OP_MR;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl.sv
// E-stage command side of the MDU: issues start / mthi / mtlo strobes, tracks the
// running operation against its expected latency and stalls dependent MDU instructions.
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT  = MUL_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int WD_SLACK = WD_SLACK_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e_valid,
    input  logic [3:0] e_cls,
    input  logic       cancel,
    input  logic       d_uses_md,
    input  logic       mdu_busy,
    output logic       mdu_start,
    output logic [2:0] mdu_op,
    output logic       hi_write,
    output logic       lo_write,
    output logic       stall_d,
    output logic       wd_err
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam int SW      = $clog2(WD_SLACK + 2);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [SW-1:0] slack_r;
    logic [2:0]    op_r;
    logic          wd_err_r;

    logic          is_start_cls_s;
    logic          is_mul_s;
    logic          is_mthi_s;
    logic          is_mtlo_s;
    logic          is_mf_s;
    logic          is_md_s;
    logic          idle_s;
    logic          issue_s;
    logic          start_s;
    logic [2:0]    dec_op_s;
    logic [CW-1:0] load_lat_s;

    // Decode the E-stage instruction class.
    always_comb begin
        is_start_cls_s = 1'b0;
        is_mul_s       = 1'b0;
        is_mthi_s      = 1'b0;
        is_mtlo_s      = 1'b0;
        is_mf_s        = 1'b0;
        case (e_cls)
            CLS_MULT, CLS_MULTU: begin
                is_start_cls_s = 1'b1;
                is_mul_s       = 1'b1;
            end
            CLS_DIV, CLS_DIVU: is_start_cls_s = 1'b1;
            CLS_MTHI:          is_mthi_s      = 1'b1;
            CLS_MTLO:          is_mtlo_s      = 1'b1;
            CLS_MFHI, CLS_MFLO: is_mf_s       = 1'b1;
            default:           is_start_cls_s = 1'b0;
        endcase
    end

    assign is_md_s    = is_start_cls_s | is_mthi_s | is_mtlo_s | is_mf_s;
    assign idle_s     = (state_r == ST_IDLE);
    assign issue_s    = e_valid & ~cancel & idle_s & ~mdu_busy;
    assign start_s    = issue_s & is_start_cls_s;
    assign dec_op_s   = cls_to_op(e_cls);
    assign load_lat_s = is_mul_s ? CW'(MUL_LAT) : CW'(DIV_LAT);

    assign mdu_start = start_s;
    assign hi_write  = issue_s & is_mthi_s;
    assign lo_write  = issue_s & is_mtlo_s;
    assign mdu_op    = start_s ? dec_op_s : op_r;
    assign wd_err    = wd_err_r;

    // The MDU raises busy only a cycle after start, so the start cycle itself must stall D.
    // An MDU instruction waiting in E (including a start blocked by foreign busy) also holds.
    assign stall_d = (d_uses_md & (start_s | ~idle_s | mdu_busy))
                   | (e_valid & is_md_s & (~idle_s | mdu_busy));

    // Operation tracking FSM with latency down-counter and watchdog slack counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            slack_r  <= '0;
            op_r     <= OP_MULU;
            wd_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r <= ST_ARM;
                        cnt_r   <= load_lat_s;
                        slack_r <= '0;
                        op_r    <= dec_op_s;
                    end
                end
                ST_ARM: begin
                    if (mdu_busy) begin
                        state_r <= ST_RUN;
                        cnt_r   <= (cnt_r != '0) ? cnt_r - CW'(1) : '0;
                    end else begin
                        wd_err_r <= 1'b1;
                        state_r  <= ST_IDLE;
                        cnt_r    <= '0;
                    end
                end
                ST_RUN: begin
                    if (!mdu_busy) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end else if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CW'(1);
                    end else if (slack_r == SW'(WD_SLACK)) begin
                        wd_err_r <= 1'b1;
                    end else begin
                        slack_r <= slack_r + SW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl: directed scenarios plus randomized traffic
// against a timeline model of the issue/track/watchdog rules and a simple MDU busy model.
module tb_mdu_issue_ctrl;
    import mdu_pkg::*;

    localparam int MUL_LAT  = 5;
    localparam int DIV_LAT  = 10;
    localparam int WD_SLACK = 2;

    logic       clk = 1'b0;
    logic       reset, e_valid, cancel, d_uses_md, mdu_busy;
    logic [3:0] e_cls;
    logic       mdu_start, hi_write, lo_write, stall_d, wd_err;
    logic [2:0] mdu_op;

    int checks = 0;
    int failures = 0;

    // Reference model: operation age since start, MDU busy countdown, expectations.
    bit         inflight = 1'b0;
    int         age = 0;
    int         lat = 0;
    bit         wd_m = 1'b0;
    logic [2:0] op_m = 3'b000;
    int         busy_left = 0;
    int         foreign_left = 0;
    bit         x_start, x_hi, x_lo, x_stall;
    logic [2:0] x_op;

    always #5 clk = ~clk;

    mdu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .WD_SLACK(WD_SLACK)) dut (
        .clk(clk), .reset(reset), .e_valid(e_valid), .e_cls(e_cls), .cancel(cancel),
        .d_uses_md(d_uses_md), .mdu_busy(mdu_busy), .mdu_start(mdu_start), .mdu_op(mdu_op),
        .hi_write(hi_write), .lo_write(lo_write), .stall_d(stall_d), .wd_err(wd_err)
    );

    function automatic logic [2:0] ref_op(input int c);
        if (c == 1) return 3'b001;
        else if (c == 2) return 3'b000;
        else if (c == 3) return 3'b011;
        else return 3'b010;
    endfunction

    task automatic apply(input bit ev, input int c, input bit can, input bit dmd, input bit rst);
        bit issue;
        reset     = rst;
        e_valid   = ev;
        e_cls     = 4'(c);
        cancel    = can;
        d_uses_md = dmd;
        mdu_busy  = (busy_left > 0) || (foreign_left > 0);
        issue     = ev && !can && !inflight && !mdu_busy;
        x_start   = issue && c >= 1 && c <= 4;
        x_hi      = issue && c == 5;
        x_lo      = issue && c == 6;
        x_op      = x_start ? ref_op(c) : op_m;
        x_stall   = (dmd && (x_start || inflight || mdu_busy))
                 || (ev && c >= 1 && c <= 8 && (inflight || mdu_busy));
        #4;
    endtask

    task automatic tick(input int blen);
        bit b;
        b = mdu_busy;
        if (inflight) begin
            if (age == 1 && !b) begin
                wd_m = 1'b1;
                inflight = 1'b0;
            end else if (!b) begin
                inflight = 1'b0;
            end else if (age > lat + WD_SLACK) begin
                wd_m = 1'b1;
            end
            age++;
        end
        if (x_start) begin
            inflight  = 1'b1;
            age       = 1;
            lat       = (e_cls <= 4'd2) ? MUL_LAT : DIV_LAT;
            op_m      = x_op;
            busy_left = blen;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        if (foreign_left > 0) foreign_left--;
        if (reset) begin
            inflight = 1'b0;
            wd_m     = 1'b0;
            op_m     = 3'b000;
            age      = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply(0, 0, 0, 1, 1); tick(0);
        apply(0, 0, 0, 1, 1); tick(0);
        apply(0, 0, 0, 1, 0);
        checks++; if (mdu_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%0b exp=0", mdu_start); end
        checks++; if (mdu_op !== 3'b000) begin failures++; $display("FAIL reset_op got=%0b exp=000", mdu_op); end
        checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall_d); end
        checks++; if ({hi_write, lo_write, wd_err} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%0b exp=000", {hi_write, lo_write, wd_err}); end
        tick(0);
    endtask

    task automatic test_mult();
        apply(1, 1, 0, 0, 0);
        checks++; if (mdu_start !== 1'b1) begin failures++; $display("FAIL mult_start got=%0b exp=1", mdu_start); end
        checks++; if (mdu_op !== 3'b001) begin failures++; $display("FAIL mult_op got=%0b exp=001", mdu_op); end
        tick(MUL_LAT);
        for (int i = 1; i <= 9; i++) begin
            apply(0, 0, 0, 1, 0);
            checks++; if (stall_d !== (i <= MUL_LAT + 1)) begin failures++; $display("FAIL mult_stall cyc=%0d got=%0b exp=%0b", i, stall_d, (i <= MUL_LAT + 1)); end
            checks++; if (mdu_start !== 1'b0 || mdu_op !== 3'b001) begin failures++; $display("FAIL mult_hold cyc=%0d start=%0b op=%0b exp=0/001", i, mdu_start, mdu_op); end
            tick(0);
        end
        apply(0, 0, 0, 0, 0);
        checks++; if (wd_err !== 1'b0) begin failures++; $display("FAIL mult_wd got=%0b exp=0", wd_err); end
        tick(0);
    endtask

    task automatic test_divu_mflo();
        apply(1, 4, 0, 1, 0);
        checks++; if (mdu_start !== 1'b1 || mdu_op !== 3'b010) begin failures++; $display("FAIL divu_start start=%0b op=%0b exp=1/010", mdu_start, mdu_op); end
        checks++; if (stall_d !== 1'b1) begin failures++; $display("FAIL divu_start_stall got=%0b exp=1", stall_d); end
        tick(DIV_LAT);
        for (int i = 1; i <= 14; i++) begin
            apply(0, 0, 0, 1, 0);
            checks++; if (stall_d !== (i <= DIV_LAT + 1)) begin failures++; $display("FAIL divu_stall cyc=%0d got=%0b exp=%0b", i, stall_d, (i <= DIV_LAT + 1)); end
            tick(0);
        end
    endtask

    task automatic test_mthi_cancel();
        apply(1, 5, 1, 0, 0);
        checks++; if ({hi_write, mdu_start, stall_d} !== 3'b000) begin failures++; $display("FAIL mthi_cancel got=%0b exp=000", {hi_write, mdu_start, stall_d}); end
        tick(0);
        apply(1, 6, 0, 0, 0);
        checks++; if (lo_write !== 1'b1 || hi_write !== 1'b0) begin failures++; $display("FAIL mtlo_after got=%0b%0b exp=01", hi_write, lo_write); end
        tick(0);
        apply(1, 5, 0, 0, 0);
        checks++; if (hi_write !== 1'b1 || lo_write !== 1'b0) begin failures++; $display("FAIL mthi_issue got=%0b%0b exp=10", hi_write, lo_write); end
        tick(0);
    endtask

    task automatic test_cancel_run();
        apply(1, 2, 0, 0, 0);
        checks++; if (mdu_start !== 1'b1 || mdu_op !== 3'b000) begin failures++; $display("FAIL multu_start start=%0b op=%0b exp=1/000", mdu_start, mdu_op); end
        tick(MUL_LAT);
        for (int i = 1; i <= 8; i++) begin
            apply(i <= 5, 1, (i >= 2 && i <= 4), 0, 0);
            checks++; if (mdu_start !== 1'b0) begin failures++; $display("FAIL cancel_run_start cyc=%0d got=%0b exp=0", i, mdu_start); end
            checks++; if (stall_d !== (i <= 5)) begin failures++; $display("FAIL cancel_run_stall cyc=%0d got=%0b exp=%0b", i, stall_d, (i <= 5)); end
            tick(0);
        end
        apply(1, 6, 0, 0, 0);
        checks++; if (lo_write !== 1'b1 || wd_err !== 1'b0) begin failures++; $display("FAIL cancel_run_done lo=%0b wd=%0b exp=1/0", lo_write, wd_err); end
        tick(0);
    endtask

    task automatic test_watchdog();
        apply(1, 1, 0, 0, 0); tick(MUL_LAT + WD_SLACK);
        for (int i = 1; i <= 10; i++) begin
            apply(0, 0, 0, 0, 0);
            checks++; if (wd_err !== 1'b0) begin failures++; $display("FAIL wd_slack_ok cyc=%0d got=%0b exp=0", i, wd_err); end
            tick(0);
        end
        apply(1, 1, 0, 0, 0); tick(MUL_LAT + WD_SLACK + 1);
        for (int i = 1; i <= 14; i++) begin
            apply(0, 0, 0, 0, 0);
            checks++; if (wd_err !== (i >= MUL_LAT + WD_SLACK + 2)) begin failures++; $display("FAIL wd_trip cyc=%0d got=%0b exp=%0b", i, wd_err, (i >= MUL_LAT + WD_SLACK + 2)); end
            tick(0);
        end
        apply(0, 0, 0, 0, 1); tick(0);
        apply(0, 0, 0, 0, 0);
        checks++; if (wd_err !== 1'b0) begin failures++; $display("FAIL wd_clear got=%0b exp=0", wd_err); end
        tick(0);
    endtask

    task automatic test_reset_mid_run();
        bit b;
        apply(1, 3, 0, 1, 0); tick(DIV_LAT);
        for (int i = 1; i <= 3; i++) begin
            apply(0, 0, 0, 1, 0); tick(0);
        end
        apply(0, 0, 0, 1, 1); tick(0);
        for (int i = 0; i < 12; i++) begin
            b = (busy_left > 0);
            apply(1, 1, 0, 0, 0);
            checks++; if (mdu_start !== !b) begin failures++; $display("FAIL rst_run_start cyc=%0d got=%0b exp=%0b", i, mdu_start, !b); end
            checks++; if (stall_d !== b) begin failures++; $display("FAIL rst_run_stall cyc=%0d got=%0b exp=%0b", i, stall_d, b); end
            if (!b) begin
                tick(MUL_LAT);
                break;
            end
            checks++; if ({mdu_op, hi_write, lo_write, wd_err} !== 6'b0) begin failures++; $display("FAIL rst_run_outs got=%0b exp=0", {mdu_op, hi_write, lo_write, wd_err}); end
            tick(0);
        end
        for (int i = 0; i < 8; i++) begin
            apply(0, 0, 0, 0, 0); tick(0);
        end
    endtask

    task automatic test_random();
        int c, blen;
        bit ev, can, dmd, rst;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            ev  = !rst && ($urandom_range(0, 3) != 0);
            can = ($urandom_range(0, 7) == 0);
            dmd = !rst && $urandom_range(0, 1);
            c   = $urandom_range(0, 15);
            if (!inflight && busy_left == 0 && foreign_left == 0 && $urandom_range(0, 24) == 0)
                foreign_left = $urandom_range(1, 3);
            apply(ev, c, can, dmd, rst);
            checks++; if (mdu_start !== x_start) begin failures++; $display("FAIL rnd_start n=%0d got=%0b exp=%0b", n, mdu_start, x_start); end
            checks++; if (mdu_op !== x_op) begin failures++; $display("FAIL rnd_op n=%0d got=%0b exp=%0b", n, mdu_op, x_op); end
            checks++; if (hi_write !== x_hi || lo_write !== x_lo) begin failures++; $display("FAIL rnd_mt n=%0d got=%0b%0b exp=%0b%0b", n, hi_write, lo_write, x_hi, x_lo); end
            checks++; if (stall_d !== x_stall) begin failures++; $display("FAIL rnd_stall n=%0d got=%0b exp=%0b", n, stall_d, x_stall); end
            checks++; if (wd_err !== wd_m) begin failures++; $display("FAIL rnd_wd n=%0d got=%0b exp=%0b", n, wd_err, wd_m); end
            blen = (c <= 2) ? MUL_LAT : DIV_LAT;
            if ($urandom_range(0, 29) == 0) blen = 0;
            else if ($urandom_range(0, 3) == 0) blen = blen + $urandom_range(1, 4);
            tick(blen);
        end
    endtask

    initial begin
        reset = 1'b1; e_valid = 1'b0; e_cls = 4'd0; cancel = 1'b0; d_uses_md = 1'b0; mdu_busy = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_mult();
        test_divu_mflo();
        test_mthi_cancel();
        test_cancel_run();
        test_watchdog();
        test_reset_mid_run();
        test_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
